// File: rtl/ntt_masked_share_gen_if.sv
// Operand, share, result and output buses of ntt_masked_share_gen.
// master = producer/consumer/multiplier side, slave = the share generator.
interface ntt_masked_share_gen_if #(
  parameter int unsigned WIDTH   = 46,
  parameter int unsigned COEFF_W = 23
);
  logic                    in_valid;
  logic                    in_ready;
  logic [COEFF_W-1:0]      u_plain;
  logic [COEFF_W-1:0]      v_plain;
  logic [WIDTH-1:0]        rnd_u;
  logic [WIDTH-1:0]        rnd_v;
  logic [1:0][WIDTH-1:0]   u_share;
  logic [1:0][WIDTH-1:0]   v_share;
  logic                    share_valid;
  logic [1:0][WIDTH-1:0]   res_shares;
  logic                    out_valid;
  logic                    out_ready;
  logic [COEFF_W-1:0]      out_data;

  modport master (
    output in_valid, u_plain, v_plain, rnd_u, rnd_v, res_shares, out_ready,
    input  in_ready, u_share, v_share, share_valid, out_valid, out_data
  );

  modport slave (
    input  in_valid, u_plain, v_plain, rnd_u, rnd_v, res_shares, out_ready,
    output in_ready, u_share, v_share, share_valid, out_valid, out_data
  );
endinterface

// File: rtl/ntt_masked_share_gen.sv
// Masks plain (u,v) pairs into arithmetic shares mod Q for the fixed-latency masked
// multiplier, tracks them through its pipe, recombines the product and buffers it.
module ntt_masked_share_gen #(
  parameter int unsigned WIDTH      = 46,
  parameter int unsigned COEFF_W    = 23,
  parameter int unsigned MULT_LAT   = 210,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  zeroize,
  ntt_masked_share_gen_if.slave bus
);
  localparam int unsigned      SUM_W   = WIDTH + 1;
  localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [COEFF_W-1:0] Q     = COEFF_W'(8380417);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic clr;
  logic accept;
  logic pop;
  logic push;

  function automatic logic [COEFF_W-1:0] mod_red(input logic [COEFF_W-1:0] x);
    return (x >= Q) ? x - Q : x;
  endfunction

  // a - r mod Q, with a, r already reduced; one extra bit covers a + Q
  function automatic logic [WIDTH-1:0] mask_share0(input logic [COEFF_W-1:0] a,
                                                   input logic [COEFF_W-1:0] r);
    logic [COEFF_W:0] d;
    if (a >= r) d = {1'b0, a} - {1'b0, r};
    else        d = {1'b0, a} + {1'b0, Q} - {1'b0, r};
    return WIDTH'(d);
  endfunction

  assign clr = reset | zeroize;

  // Masking stage
  logic [COEFF_W-1:0]    u_a, v_a, u_r, v_r;
  logic [1:0][WIDTH-1:0] u_sh, v_sh;
  logic                  share_valid_q;

  always_comb begin
    u_a = mod_red(bus.u_plain);
    v_a = mod_red(bus.v_plain);
    u_r = mod_red(bus.rnd_u[COEFF_W-1:0]);
    v_r = mod_red(bus.rnd_v[COEFF_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      u_sh          <= '0;
      v_sh          <= '0;
      share_valid_q <= 1'b0;
    end else begin
      share_valid_q <= accept;
      if (accept) begin
        u_sh[1] <= WIDTH'(u_r);
        u_sh[0] <= mask_share0(u_a, u_r);
        v_sh[1] <= WIDTH'(v_r);
        v_sh[0] <= mask_share0(v_a, v_r);
      end
    end
  end

  logic unused_rnd;
  assign unused_rnd = ^{bus.rnd_u[WIDTH-1:COEFF_W], bus.rnd_v[WIDTH-1:COEFF_W]};

  // Valid shadow of the multiplier pipe; its tail marks res_shares live
  logic [MULT_LAT-1:0] vpipe;

  always_ff @(posedge clk) begin
    if (clr) vpipe <= '0;
    else     vpipe <= {vpipe[MULT_LAT-2:0], share_valid_q};
  end

  // Recombine stage
  logic [SUM_W-1:0]   res_sum;
  logic [COEFF_W-1:0] prod;
  logic               rec_valid;
  logic [COEFF_W-1:0] rec_data;

  always_comb begin
    res_sum = {1'b0, bus.res_shares[0]} + {1'b0, bus.res_shares[1]};
    prod    = (res_sum >= SUM_W'(Q)) ? COEFF_W'(res_sum - SUM_W'(Q)) : COEFF_W'(res_sum);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rec_valid <= 1'b0;
      rec_data  <= '0;
    end else begin
      rec_valid <= vpipe[MULT_LAT-1];
      if (vpipe[MULT_LAT-1]) rec_data <= prod;
    end
  end

  // Output FIFO with a registered head so out_data comes straight from a flop
  logic [COEFF_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_next;
  logic [CNT_W-1:0]   fifo_cnt, fifo_cnt_next;
  logic [COEFF_W-1:0] head_q, head_next;
  logic               out_valid_q;

  assign push = rec_valid;
  assign pop  = out_valid_q & bus.out_ready;

  always_comb begin
    rd_next       = rd_ptr + PTR_W'(pop);
    fifo_cnt_next = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    head_next     = (push && (rd_next == wr_ptr)) ? rec_data : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      mem         <= '{default: '0};
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rec_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      rd_ptr      <= rd_next;
      fifo_cnt    <= fifo_cnt_next;
      head_q      <= head_next;
      out_valid_q <= (fifo_cnt_next != '0);
    end
  end

  // Credits: ops in flight plus FIFO entries, so a push never finds the FIFO full
  logic [CNT_W-1:0] cnt;

  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (clr)                 cnt <= '0;
    else if (accept && !pop) cnt <= cnt + CNT_W'(1);
    else if (pop && !accept) cnt <= cnt - CNT_W'(1);
  end

  assign bus.in_ready    = (cnt < DEPTH_C) && !clr;
  assign bus.u_share     = u_sh;
  assign bus.v_share     = v_sh;
  assign bus.share_valid = share_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = head_q;

  a_no_push_full: assert property (@(posedge clk) disable iff (clr)
                                   !(push && (fifo_cnt == DEPTH_C)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (clr)
                                   !(pop && (fifo_cnt == '0)));
  a_cnt_bound:    assert property (@(posedge clk) disable iff (clr)
                                   cnt <= DEPTH_C);
endmodule

// File: tb/tb_ntt_masked_share_gen.sv
// Bench for ntt_masked_share_gen: a fixed-latency multiplier model returning real
// product shares, and a queue of expected products computed directly as u*v mod Q.
module tb_ntt_masked_share_gen;
  localparam int unsigned WIDTH = 46;
  localparam int unsigned COEFF_W = 23;
  localparam int unsigned L = 210;
  localparam int unsigned DEPTH = 4;
  localparam longint unsigned Q = 8380417;

  logic clk = 1'b0;
  logic reset;
  logic zeroize;

  ntt_masked_share_gen_if #(.WIDTH(WIDTH), .COEFF_W(COEFF_W)) bus ();

  ntt_masked_share_gen #(.WIDTH(WIDTH), .COEFF_W(COEFF_W), .MULT_LAT(L), .FIFO_DEPTH(DEPTH))
    dut (.clk(clk), .reset(reset), .zeroize(zeroize), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Multiplier model: res for the shares seen in cycle c appears in cycle c+L
  logic [WIDTH-1:0] ring0 [L+1];
  logic [WIDTH-1:0] ring1 [L+1];
  bit               force_res = 1'b0;
  logic [WIDTH-1:0] force0, force1;

  initial begin
    for (int i = 0; i <= int'(L); i++) begin
      ring0[i] = WIDTH'(longint'($urandom) % Q);
      ring1[i] = WIDTH'(longint'($urandom) % Q);
    end
  end

  always @(negedge clk) begin
    longint unsigned uu, vv, p, r0;
    int w, r;
    w = (cyc + int'(L)) % int'(L + 1);
    r = cyc % int'(L + 1);
    if (bus.share_valid === 1'b1) begin
      uu = (64'(bus.u_share[0]) + 64'(bus.u_share[1])) % Q;
      vv = (64'(bus.v_share[0]) + 64'(bus.v_share[1])) % Q;
      p  = (uu * vv) % Q;
      r0 = longint'($urandom) % Q;
      if (force_res) begin
        ring0[w] = force0;
        ring1[w] = force1;
      end else begin
        ring0[w] = WIDTH'(r0);
        ring1[w] = WIDTH'((p + Q - r0) % Q);
      end
    end else begin
      ring0[w] = WIDTH'(longint'($urandom) % Q);
      ring1[w] = WIDTH'(longint'($urandom) % Q);
    end
    bus.res_shares[0] = ring0[r];
    bus.res_shares[1] = ring1[r];
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  longint unsigned exp_q[$];
  bit acc;
  bit popped;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd46();
    return WIDTH'({$urandom(), $urandom()});
  endfunction

  function automatic logic [COEFF_W-1:0] rnd23();
    return COEFF_W'($urandom());
  endfunction

  // One clock cycle: drive, then check in_ready and any pop against the model
  task automatic step(input bit iv, input logic [COEFF_W-1:0] u, input logic [COEFF_W-1:0] v,
                      input logic [WIDTH-1:0] ru, input logic [WIDTH-1:0] rv,
                      input bit ordy, input bit zer);
    logic [63:0] exp_rdy;
    @(negedge clk);
    bus.in_valid = iv;  bus.u_plain = u;  bus.v_plain = v;
    bus.rnd_u = ru;     bus.rnd_v = rv;   bus.out_ready = ordy;
    zeroize = zer;
    #1;
    exp_rdy = (exp_q.size() < int'(DEPTH) && !zer && !reset) ? 64'd1 : 64'd0;
    chk("in_ready", 64'(bus.in_ready), exp_rdy);
    acc    = iv && (bus.in_ready === 1'b1);
    popped = (bus.out_valid === 1'b1) && ordy && !zer;
    if (popped) begin
      if (exp_q.size() == 0) chk("out_valid_when_empty", 64'(bus.out_valid), 64'd0);
      else                   chk("out_data", 64'(bus.out_data), exp_q.pop_front());
    end
    if (acc) exp_q.push_back(((longint'(u) % Q) * (longint'(v) % Q)) % Q);
    if (zer) exp_q.delete();
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, rnd23(), rnd23(), rnd46(), rnd46(), ordy, 1'b0);
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      idle(1'b1);
      k++;
    end
    if (k == bound) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    idle(1'b1);
    chk("drained_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int t0, n_acc, n_ov;
    logic [63:0] s0, s1;
    reset = 1'b1;  zeroize = 1'b0;
    bus.in_valid = 1'b0;  bus.u_plain = '0;  bus.v_plain = '0;
    bus.rnd_u = '0;  bus.rnd_v = '0;  bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_share_valid", 64'(bus.share_valid), 64'd0);
    chk("rst_u_share", 64'(bus.u_share[0]) | 64'(bus.u_share[1]), 64'd0);
    chk("rst_v_share", 64'(bus.v_share[0]) | 64'(bus.v_share[1]), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Masking: u=5 with r=Q+3 (reduced to 3)
    step(1'b1, 23'd5, 23'd0, {23'($urandom), 23'(Q + 3)}, rnd46(), 1'b1, 1'b0);
    idle(1'b1);
    chk("mask_sv", 64'(bus.share_valid), 64'd1);
    chk("mask5_share1", 64'(bus.u_share[1]), 64'd3);
    chk("mask5_share0", 64'(bus.u_share[0]), 64'd2);
    idle(1'b1);
    chk("mask_sv_one_cycle", 64'(bus.share_valid), 64'd0);
    chk("mask_hold", 64'(bus.u_share[1]), 64'd3);

    // Masking: u=0 with r=7 wraps to Q-7
    step(1'b1, 23'd0, 23'd9, {23'($urandom), 23'd7}, rnd46(), 1'b1, 1'b0);
    idle(1'b1);
    chk("mask0_share0", 64'(bus.u_share[0]), 64'(Q - 7));
    chk("mask0_share1", 64'(bus.u_share[1]), 64'd7);

    // Masking: u=Q+1 behaves as 1
    step(1'b1, 23'(Q + 1), 23'd9, rnd46(), rnd46(), 1'b1, 1'b0);
    idle(1'b1);
    s0 = 64'(bus.u_share[0]);  s1 = 64'(bus.u_share[1]);
    chk("maskq1_sum", (s0 + s1) % Q, 64'd1);
    chk("maskq1_ranges", 64'((s0 < Q) && (s1 < Q)), 64'd1);
    chk("maskv_sum", (64'(bus.v_share[0]) + 64'(bus.v_share[1])) % Q, 64'd9);
    drain(800);

    // Latency of a single op with a real-share multiplier
    step(1'b1, 23'd3, 23'd4, rnd46(), rnd46(), 1'b1, 1'b0);
    t0 = cyc;
    n_ov = 0;
    for (int k = 0; k < 400 && n_ov == 0; k++) begin
      idle(1'b1);
      if (popped) begin
        n_ov = 1;
        chk("latency", 64'(cyc), 64'(t0 + 3 + int'(L)));
        chk("prod_3x4", 64'(bus.out_data), 64'd12);
      end
    end
    if (n_ov == 0) chk("latency_timeout", 64'(bus.out_valid), 64'd1);

    // Recombination boundaries from forced result shares
    force0 = WIDTH'(2);  force1 = WIDTH'(Q - 1);  force_res = 1'b1;
    step(1'b1, 23'd7, 23'd11, rnd46(), rnd46(), 1'b1, 1'b0);
    exp_q[exp_q.size() - 1] = 1;
    idle(1'b1);
    force_res = 1'b0;
    drain(800);
    force0 = '0;  force1 = '0;  force_res = 1'b1;
    step(1'b1, 23'd7, 23'd11, rnd46(), rnd46(), 1'b1, 1'b0);
    exp_q[exp_q.size() - 1] = 0;
    idle(1'b1);
    force_res = 1'b0;
    drain(800);

    // Back-pressure: only DEPTH of 6 back-to-back requests get in
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, rnd23(), rnd23(), rnd46(), rnd46(), 1'b0, 1'b0);
      n_acc += int'(acc);
    end
    chk("bp_accepted", 64'(n_acc), 64'(DEPTH));
    for (int i = 0; i < int'(L) + 10; i++)
      step(1'b1, rnd23(), rnd23(), rnd46(), rnd46(), 1'b0, 1'b0);
    chk("bp_full_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, rnd23(), rnd23(), rnd46(), rnd46(), 1'b1, 1'b0);
      chk("bp_pop_no_accept", 64'(acc), 64'd0);
      step(1'b1, rnd23(), rnd23(), rnd46(), rnd46(), 1'b0, 1'b0);
      chk("bp_reaccept", 64'(acc), 64'd1);
    end

    // Full FIFO with producer and consumer both always active
    for (int i = 0; i < 40; i++)
      step(1'b1, rnd23(), rnd23(), rnd46(), rnd46(), 1'b1, 1'b0);
    drain(2000);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom), rnd23(), rnd23(), rnd46(), rnd46(), ($urandom % 4) != 0, 1'b0);
    drain(2000);

    // Zeroize with ops in flight
    for (int i = 0; i < 3; i++)
      step(1'b1, rnd23(), rnd23(), rnd46(), rnd46(), 1'b1, 1'b0);
    repeat (50) idle(1'b1);
    step(1'b1, rnd23(), rnd23(), rnd46(), rnd46(), 1'b0, 1'b1);
    chk("zer_no_accept", 64'(acc), 64'd0);
    idle(1'b1);
    chk("zer_share_valid", 64'(bus.share_valid), 64'd0);
    n_ov = 0;
    for (int i = 0; i < int'(L) + 20; i++) begin
      idle(1'b1);
      n_ov += int'(bus.out_valid === 1'b1);
    end
    chk("zer_dropped", 64'(n_ov), 64'd0);
    step(1'b1, 23'(Q - 1), 23'(Q - 1), rnd46(), rnd46(), 1'b1, 1'b0);
    chk("zer_new_accept", 64'(acc), 64'd1);
    drain(800);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
